// File: rtl/rbus_xbar_if.sv
// rbus_xbar_if: master-side load/store bus plus broadcast slave bus
// of the rbus crossbar, grouped for the environment and the crossbar.
interface rbus_xbar_if #(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic                  m_req_i;
  logic                  m_we_i;
  logic [AW-1:0]         m_addr_i;
  logic [DW-1:0]         m_wdata_i;
  logic [DW/8-1:0]       m_wstrb_i;
  logic                  m_ready_o;
  logic [DW-1:0]         m_rdata_o;
  logic                  m_err_o;
  logic [NUM_SLV-1:0]    s_req_o;
  logic                  s_we_o;
  logic [AW-1:0]         s_addr_o;
  logic [DW-1:0]         s_wdata_o;
  logic [DW/8-1:0]       s_wstrb_o;
  logic [NUM_SLV-1:0]    s_ready_i;
  logic [NUM_SLV*DW-1:0] s_rdata_i;

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, m_wstrb_i,
    input  m_ready_o, m_rdata_o, m_err_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o,
    output s_ready_i, s_rdata_i
  );

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_wstrb_i,
    output m_ready_o, m_rdata_o, m_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wstrb_o,
    input  s_ready_i, s_rdata_i
  );
endinterface

// File: rtl/rbus_xbar.sv
// rbus_xbar: one load/store master to NUM_SLV base/mask decoded slaves
// with wait states, per-access timeout and error responses.
module rbus_xbar #(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {
    32'h0000_0000, 32'h4000_0000,
    32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {
    32'h8000_0000, 32'hF000_0000,
    32'hF000_0000, 32'hF000_0000},
  parameter int TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  rbus_xbar_if.slave bus,
  output logic [7:0] err_cnt_o
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam int BW = DW / 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e             state_q;
  logic [SW-1:0]      sel_q;
  logic [NUM_SLV-1:0] req_q;
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [BW-1:0]      wstrb_q;
  logic [CW-1:0]      cnt_q;
  logic               rdy_q;
  logic               err_q;
  logic [DW-1:0]      rdata_q;
  logic [7:0]         err_cnt_q;

  logic               hit_d;
  logic [SW-1:0]      hit_idx_d;
  logic               sel_rdy_d;
  logic [DW-1:0]      sel_rdata_d;
  logic [7:0]         err_cnt_d;

  // Scan downwards so the lowest-index hit is the last one written.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((bus.m_addr_i & SLV_MASK[i*AW +: AW])
          == SLV_BASE[i*AW +: AW]) begin
        hit_d     = 1'b1;
        hit_idx_d = SW'(i);
      end
    end
  end

  always_comb begin
    sel_rdy_d   = 1'b0;
    sel_rdata_d = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_rdy_d   = bus.s_ready_i[i];
        sel_rdata_d = bus.s_rdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      req_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.m_req_i) begin
            we_q    <= bus.m_we_i;
            addr_q  <= bus.m_addr_i;
            wdata_q <= bus.m_wdata_i;
            wstrb_q <= bus.m_wstrb_i;
            sel_q   <= hit_idx_d;
            if (hit_d) begin
              state_q <= ACCESS;
              req_q   <= NUM_SLV'(1) << hit_idx_d;
              cnt_q   <= '0;
            end else begin
              state_q   <= RESP;
              rdy_q     <= 1'b1;
              err_q     <= 1'b1;
              rdata_q   <= ERR_DATA;
              err_cnt_q <= err_cnt_d;
            end
          end
        end
        ACCESS: begin
          // Ready checked first: a ready on the last cycle beats the timeout.
          if (sel_rdy_d) begin
            state_q <= RESP;
            req_q   <= '0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : sel_rdata_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= RESP;
            req_q     <= '0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= ERR_DATA;
            err_cnt_q <= err_cnt_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.m_ready_o = rdy_q;
  assign bus.m_rdata_o = rdata_q;
  assign bus.m_err_o   = err_q;
  assign bus.s_req_o   = req_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_addr_o  = addr_q;
  assign bus.s_wdata_o = wdata_q;
  assign bus.s_wstrb_o = wstrb_q;
  assign err_cnt_o     = err_cnt_q;

endmodule
